rgb_window_gen: RTL
===================

# rgb_window_gen

Streaming 3x3 window generator that feeds the Gaussian convolution stage. It accepts a raster-order RGB pixel stream, one pixel per beat. Two line buffers plus a 3x3 shift-register array assemble the 3x3 neighbourhood for each of R, G and B. It presents each complete interior window on a valid/ready interface: `win_valid` out, `win_ready` in (driven by the convolution stage's `conv_ready`).

## Interface
- `IMG_W`, 16: image width in pixels; must be ≥ 3.
- `IMG_H`, 16: image height in pixels; must be ≥ 3.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `pix_in`  in  24  input pixel, packed {R[23:16], G[15:8], B[7:0]}.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  block accepts `pix_in` this cycle.
- `win_R`, `win_G`, `win_B`  out  72 each  packed 3x3 window.
  - Position k (1..9) occupies bits [8k-1:8k-8].
  - Row-major order: 1 = top-left, 5 = centre, 9 = bottom-right.
- `win_valid`  out  1  window outputs are valid.
- `win_ready`  in  1  downstream accepts the window.
- `win_last`  out  1  qualifies the final window of a frame; valid only while `win_valid` = 1.

## Operation
- Beat accepted when `pix_valid && pix_ready`. `pix_ready = !win_valid || win_ready` (combinational).
- Counters:
  - `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted beat.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_H-1, IMG_W-1), both wrap to 0; the next beat is frame 2 pixel (0,0).
- Line buffers on an accepted beat at column c:
  - Read LB1[c] (row-2) and LB0[c] (row-1).
  - Write LB1[c] ← old LB0[c] and LB0[c] ← `pix_in`. Read-before-write at the same address.
- Window array:
  - The three columns shift left on each accepted beat.
  - The new right column is {LB1[c], LB0[c], `pix_in`} for the top, middle and bottom rows.
- Window emission:
  - A window is emitted for an accepted beat at (row, col) with row ≥ 2 and col ≥ 2.
  - Its centre is pixel (row-1, col-1).
  - `win_*` and `win_valid` are registered and load the cycle after the accepting edge.
- Frame output:
  - (IMG_W-2)·(IMG_H-2) windows per frame; no border windows.
  - `win_last` = 1 for the window produced by pixel (IMG_H-1, IMG_W-1).
- Output register:
  - Clears `win_valid` when the window is accepted and no new window loads.
  - A simultaneous accept and new window reloads with `win_valid` held at 1.
- Line-buffer contents are never cleared. Stale data is harmless: windows start only at row 2, and columns refill within each row before col 2.

## Timing
- Reset values: `win_valid` = 0, `win_last` = 0, `win_R`/`win_G`/`win_B` = 0, `col` = `row` = 0. With `win_valid` = 0, `pix_ready` = 1.
- Latency: window on the outputs 1 cycle after the edge accepting its bottom-right pixel.
- Throughput: 1 pixel and 1 window per cycle when `win_ready` = 1 continuously.
- Backpressure:
  - While `win_valid && !win_ready`, all window outputs are held stable and `pix_ready` = 0.
  - No pixel is lost or duplicated.
- Beats with row < 2 or col < 2 never stall, unless a previous window is still pending.
- Reset mid-frame: counters and outputs clear immediately. A pending window is discarded. The next accepted pixel is (0,0).

## Structure
- Package `rgb_window_pkg`:
  - `PIX_W` = 8 and `NCH` = 3.
  - typedef `rgb_t` (packed R, G, B).
  - Function `win_slice(k)` returning the bit offset for window position k.
- Sub-module `line_buf`:
  - IMG_W × 24-bit, one read and one write at the same address per cycle, read-before-write.
  - Instantiated twice: LB0 and LB1.

## Test plan
- 4x4 frame, all channels = 4·row+col, `win_ready` = 1 continuously:
  - Exactly 4 windows.
  - First window R = {0,1,2,4,5,6,8,9,10}; fourth window R = {5,6,7,9,10,11,13,14,15}, with `win_last` = 1 only on it.
- Constant frame R=0xFF, G=0x80, B=0x00:
  - Every window byte is uniform per channel.
  - The downstream Gaussian stage yields 0x00FF, 0x0080, 0x0000.
- Backpressure: hold `win_ready` = 0 for 5 cycles after the first window.
  - `pix_ready` = 0 and `win_*` stable for those 5 cycles.
  - Resuming gives the same 4-window sequence as the unstalled run.
- Random `pix_valid` gaps plus random `win_ready` on a 16x16 frame: 196 windows, matching a software 3x3 reference model bit-exactly.
- Two back-to-back 4x4 frames with different content: the second frame's windows contain no first-frame pixels, and `win_last` pulses twice.
- Assert `rst` after 7 pixels of a frame, then send a full 4x4 frame:
  - All outputs are 0 during reset.
  - The post-reset windows equal those of the first scenario.

Source files
------------

// File: rtl/rgb_window_pkg.sv
// Shared types and constants for the RGB 3x3 window generator.
package rgb_window_pkg;

   localparam int PIX_W = 8;              // bits per colour channel
   localparam int NCH   = 3;              // colour channels per pixel
   localparam int WIN_W = 9 * PIX_W;      // one packed 3x3 window, one channel

   // One raster pixel, laid out exactly as it arrives on pix_in.
   typedef struct packed {
      logic [PIX_W-1:0] r;
      logic [PIX_W-1:0] g;
      logic [PIX_W-1:0] b;
   } rgb_t;

   // Bit offset of window position k (1 = top-left ... 9 = bottom-right).
   function automatic int win_slice(input int k);
      return (k - 1) * PIX_W;
   endfunction

endpackage

// File: rtl/rgb_window_gen_if.sv
// Pixel-in / window-out stream bundle between the raster source, the window
// generator and the convolution stage.
interface rgb_window_gen_if;
   import rgb_window_pkg::*;

   logic [NCH*PIX_W-1:0] pix_in;
   logic                 pix_valid;
   logic                 pix_ready;
   logic [WIN_W-1:0]     win_R;
   logic [WIN_W-1:0]     win_G;
   logic [WIN_W-1:0]     win_B;
   logic                 win_valid;
   logic                 win_ready;
   logic                 win_last;

   // Environment side: drives pixels and window backpressure.
   modport master (
      output pix_in, pix_valid, win_ready,
      input  pix_ready, win_R, win_G, win_B, win_valid, win_last
   );

   // Window generator side.
   modport slave (
      input  pix_in, pix_valid, win_ready,
      output pix_ready, win_R, win_G, win_B, win_valid, win_last
   );

endinterface

// File: rtl/line_buf.sv
// One image line of pixels: asynchronous read and synchronous write at the
// same address, so a read in the writing cycle returns the previous contents.
module line_buf
   import rgb_window_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  rgb_t                     wdata,
   output rgb_t                     rdata
);

   rgb_t mem [DEPTH];

   assign rdata = mem[addr];

   // Store the incoming pixel; the old word has already been read out above.
   // NOTE: the storage array has no reset -- stale lines are never used before
   // they are overwritten, and a reset would stop this mapping onto RAM.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/rgb_window_gen.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 shift array,
// and every complete interior window is presented on a registered
// valid/ready output.
module rgb_window_gen
   import rgb_window_pkg::*;
#(
   parameter int IMG_W = 16,
   parameter int IMG_H = 16
) (
   input  logic             clk,
   input  logic             rst,
   rgb_window_gen_if.slave  bus
);

   localparam int            CW       = $clog2(IMG_W);
   localparam int            RW       = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic             accept;
   logic             emit;
   rgb_t             pix;
   rgb_t             lb0_rd;
   rgb_t             lb1_rd;
   rgb_t             win_arr [3][3];
   rgb_t             nxt_arr [3][3];
   logic [WIN_W-1:0] nxt_R;
   logic [WIN_W-1:0] nxt_G;
   logic [WIN_W-1:0] nxt_B;

   assign pix           = rgb_t'(bus.pix_in);
   assign bus.pix_ready = !bus.win_valid || bus.win_ready;
   assign accept        = bus.pix_valid && bus.pix_ready;
   assign emit          = accept && (row >= RW'(2)) && (col >= CW'(2));

   // LB0 holds row-1, LB1 holds row-2; LB1 is refilled from LB0's old word.
   line_buf #(.DEPTH(IMG_W)) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (pix),
      .rdata (lb0_rd)
   );

   line_buf #(.DEPTH(IMG_W)) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   // Raster position of the next pixel to be accepted.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Window after this beat: shift columns left, new right column from the line buffers.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nxt_arr[r][0] = win_arr[r][1];
         nxt_arr[r][1] = win_arr[r][2];
      end
      nxt_arr[0][2] = lb1_rd;
      nxt_arr[1][2] = lb0_rd;
      nxt_arr[2][2] = pix;
   end

   // Pack the next window row-major into the per-channel output buses.
   // NOTE: defaults assigned first so no path leaves a bit unassigned (no latch).
   always_comb begin
      nxt_R = '0;
      nxt_G = '0;
      nxt_B = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            nxt_R[win_slice(r*3 + c + 1) +: PIX_W] = nxt_arr[r][c].r;
            nxt_G[win_slice(r*3 + c + 1) +: PIX_W] = nxt_arr[r][c].g;
            nxt_B[win_slice(r*3 + c + 1) +: PIX_W] = nxt_arr[r][c].b;
         end
      end
   end

   // 3x3 shift array, advanced once per accepted pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_arr[r][c] <= '0;
      end else if (accept) begin
         win_arr <= nxt_arr;
      end
   end

   // Output register: load a new window, or drop valid once it is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.win_valid <= 1'b0;
         bus.win_last  <= 1'b0;
         bus.win_R     <= '0;
         bus.win_G     <= '0;
         bus.win_B     <= '0;
      end else if (emit) begin
         bus.win_valid <= 1'b1;
         bus.win_last  <= (row == ROW_LAST) && (col == COL_LAST);
         bus.win_R     <= nxt_R;
         bus.win_G     <= nxt_G;
         bus.win_B     <= nxt_B;
      end else if (bus.win_ready) begin
         bus.win_valid <= 1'b0;
      end
   end

endmodule
